uart_out_demux: RTL

Host-to-UART demultiplexer: the scheduler that drains the shared host RX FIFO (USB -> FPGA) and routes each byte to one UART transmit FIFO. The host stream is a sequence of two-byte frames: first the UART index, then the payload byte. This is the inverse framing of the UART -> USB multiplexer. The block sits between the USB host FIFO and the per-channel UART TX FIFOs, and owns the FIFO read strobe and the per-UART write strobes.

---
 rtl/uart_out_demux.sv | 112 +++++++++++
 1 files changed

// File: rtl/uart_out_demux.sv
// Host-to-UART demultiplexer: drains {index, payload} frames from the host FIFO and
// steers each payload byte to the addressed UART TX FIFO.
module uart_out_demux #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned UART_COUNT = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_read,
    input  logic [DATA_BITS-1:0]  i_fifo_data,
    input  logic [UART_COUNT-1:0] i_full,
    output logic [UART_COUNT-1:0] o_write,
    output logic [DATA_BITS-1:0]  o_data,
    output logic                  o_bad_index
);

    localparam logic [DATA_BITS-1:0] LP_COUNT = DATA_BITS'(UART_COUNT);

    typedef enum logic [1:0] {
        StIndexWait,
        StIndexPop,
        StValueWait,
        StValuePop
    } state_e;

    state_e                  r_state, w_state_next;
    logic [DATA_BITS-1:0]    r_index, w_index_next;
    logic                    r_fifo_read, w_fifo_read_next;
    logic [UART_COUNT-1:0]   r_write, w_write_next;
    logic [DATA_BITS-1:0]    r_data, w_data_next;
    logic                    r_bad_index, w_bad_index_next;

    logic [UART_COUNT-1:0]   w_sel;
    logic                    w_index_valid;
    logic                    w_sel_full;

    // One-hot decode of the latched index, compared at full width (no truncation).
    for (genvar g = 0; g < UART_COUNT; g++) begin : g_sel
        assign w_sel[g] = (r_index == DATA_BITS'(g));
    end

    assign w_index_valid = (r_index < LP_COUNT);
    assign w_sel_full    = |(w_sel & i_full);

    always_comb begin
        w_state_next     = r_state;
        w_index_next     = r_index;
        w_fifo_read_next = 1'b0;
        w_write_next     = '0;
        w_data_next      = '0;
        w_bad_index_next = 1'b0;

        case (r_state)
            StIndexWait: begin
                if (!i_fifo_empty) begin
                    w_index_next     = i_fifo_data;
                    w_fifo_read_next = 1'b1;
                    w_state_next     = StIndexPop;
                end
            end
            StIndexPop: begin
                w_state_next = StValueWait;
            end
            StValueWait: begin
                if (!i_fifo_empty) begin
                    if (!w_index_valid) begin
                        w_fifo_read_next = 1'b1;
                        w_bad_index_next = 1'b1;
                        w_state_next     = StValuePop;
                    end else if (!w_sel_full) begin
                        w_write_next     = w_sel;
                        w_data_next      = i_fifo_data;
                        w_fifo_read_next = 1'b1;
                        w_state_next     = StValuePop;
                    end
                    // Valid index with a full target: hold the head byte until space frees up.
                end
            end
            StValuePop: begin
                w_state_next = StIndexWait;
            end
            default: begin
                w_state_next = StIndexWait;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIndexWait;
            r_index     <= '0;
            r_fifo_read <= 1'b0;
            r_write     <= '0;
            r_data      <= '0;
            r_bad_index <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_index     <= w_index_next;
            r_fifo_read <= w_fifo_read_next;
            r_write     <= w_write_next;
            r_data      <= w_data_next;
            r_bad_index <= w_bad_index_next;
        end
    end

    assign o_fifo_read = r_fifo_read;
    assign o_write     = r_write;
    assign o_data      = r_data;
    assign o_bad_index = r_bad_index;

endmodule
